// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - PS/2 scan-code decoder, per-class queues and frame-rate command arbiter
// Three class queues feed a single command slot that is refilled only on frame_tick.

module key_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       empty,
  output logic       drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop_en;
  logic          wr_en;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_en   = pop & ~empty;
  // Full is judged after the same-edge pop, so a pop frees room for this write.
  assign wr_en    = push & ~flush & (~full | pop_en);
  assign drop     = push & ~flush & full & ~pop_en;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_en};
    end
  end
endmodule

module key_event_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done,
  input  logic [7:0] tasta,
  input  logic       frame_tick,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [1:0] cmd_src,
  output logic [7:0] drop_count
);
  logic       done_q;
  logic       break_f;
  logic       ext_f;
  logic       last_grant_p2;
  logic       byte_evt;
  logic       plain;
  logic       push_c, push_p1, push_p2;
  logic       pop_c, pop_p1, pop_p2;
  logic       empty_c, empty_p1, empty_p2;
  logic       drop_c, drop_p1, drop_p2;
  logic [7:0] data_c, data_p1, data_p2;
  logic       grant_evt;
  logic       flush_players;

  assign byte_evt = done & ~done_q;
  assign plain    = byte_evt & (tasta != 8'hF0) & (tasta != 8'hE0) & ~break_f & ~ext_f;

  always_comb begin
    push_c  = 1'b0;
    push_p1 = 1'b0;
    push_p2 = 1'b0;
    if (plain) begin
      case (tasta)
        8'h76, 8'h29, 8'h16, 8'h1E: push_c  = 1'b1;
        8'h1C, 8'h23:               push_p1 = 1'b1;
        8'h3B, 8'h4B:               push_p2 = 1'b1;
        default: ;
      endcase
    end
  end

  // Grant decisions use pre-edge emptiness, so a same-edge write waits a frame.
  assign grant_evt     = frame_tick & (~cmd_valid | cmd_ack);
  assign pop_c         = grant_evt & ~empty_c;
  assign pop_p1        = grant_evt & empty_c & ~empty_p1 & (empty_p2 | last_grant_p2);
  assign pop_p2        = grant_evt & empty_c & ~empty_p2 & (empty_p1 | ~last_grant_p2);
  assign flush_players = pop_c & (data_c == 8'h76);

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo_c (
    .clock(clock), .reset(reset), .flush(1'b0), .push(push_c), .push_data(tasta),
    .pop(pop_c), .pop_data(data_c), .empty(empty_c), .drop(drop_c)
  );

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo_p1 (
    .clock(clock), .reset(reset), .flush(flush_players), .push(push_p1), .push_data(tasta),
    .pop(pop_p1), .pop_data(data_p1), .empty(empty_p1), .drop(drop_p1)
  );

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo_p2 (
    .clock(clock), .reset(reset), .flush(flush_players), .push(push_p2), .push_data(tasta),
    .pop(pop_p2), .pop_data(data_p2), .empty(empty_p2), .drop(drop_p2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q  <= 1'b0;
      break_f <= 1'b0;
      ext_f   <= 1'b0;
    end else begin
      done_q <= done;
      if (byte_evt) begin
        if (tasta == 8'hF0)
          break_f <= 1'b1;
        else if (tasta == 8'hE0)
          ext_f <= 1'b1;
        else begin
          break_f <= 1'b0;
          ext_f   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid     <= 1'b0;
      cmd_code      <= 8'h00;
      cmd_src       <= 2'd0;
      last_grant_p2 <= 1'b1;
      drop_count    <= 8'h00;
    end else begin
      if (pop_c) begin
        cmd_valid <= 1'b1;
        cmd_code  <= data_c;
        cmd_src   <= 2'd0;
      end else if (pop_p1) begin
        cmd_valid     <= 1'b1;
        cmd_code      <= data_p1;
        cmd_src       <= 2'd1;
        last_grant_p2 <= 1'b0;
      end else if (pop_p2) begin
        cmd_valid     <= 1'b1;
        cmd_code      <= data_p2;
        cmd_src       <= 2'd2;
        last_grant_p2 <= 1'b1;
      end else if (cmd_ack) begin
        cmd_valid <= 1'b0;
      end
      if ((drop_c | drop_p1 | drop_p2) && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed self-checking bench for key_event_arbiter
module tb_key_event_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       done = 1'b0;
  logic [7:0] tasta = 8'h00;
  logic       frame_tick = 1'b0;
  logic       cmd_ack = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [1:0] cmd_src;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail = 0;

  key_event_arbiter #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .done(done), .tasta(tasta),
    .frame_tick(frame_tick), .cmd_ack(cmd_ack), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cmd_src(cmd_src), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tasta = b;
    done  = 1'b1;
    tick();
    done  = 1'b0;
    tick();
  endtask

  task automatic frame(input logic ack);
    frame_tick = 1'b1;
    cmd_ack    = ack;
    tick();
    frame_tick = 1'b0;
    cmd_ack    = 1'b0;
  endtask

  task automatic expect_cmd(input string tag, input logic [7:0] code, input logic [1:0] src);
    check({tag, "_valid"}, cmd_valid, 1);
    check({tag, "_code"}, cmd_code, code);
    check({tag, "_src"}, cmd_src, src);
  endtask

  logic [7:0] rr_code [5];
  logic [1:0] rr_src  [5];

  initial begin
    rr_code = '{8'h1C, 8'h3B, 8'h1C, 8'h3B, 8'h1C};
    rr_src  = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

    do_reset();
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 8'h00);
    check("rst_src", cmd_src, 0);
    check("rst_drop", drop_count, 0);

    // Basic grant, hold, ack
    send_byte(8'h1C);
    frame(1'b0);
    expect_cmd("t1_grant", 8'h1C, 2'd1);
    for (int i = 0; i < 3; i++) tick();
    expect_cmd("t1_hold", 8'h1C, 2'd1);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    check("t1_ack_clear", cmd_valid, 0);
    frame(1'b0);
    check("t1_empty_tick", cmd_valid, 0);

    // Break / extended stripping
    do_reset();
    send_byte(8'h23);
    send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    frame(1'b0);
    expect_cmd("t2_grant", 8'h23, 2'd1);
    frame(1'b1);
    check("t2_only_one", cmd_valid, 0);
    check("t2_drop", drop_count, 0);

    // Round-robin between players
    do_reset();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'h3B); send_byte(8'h3B);
    frame(1'b0);
    expect_cmd("t3_rr0", rr_code[0], rr_src[0]);
    for (int i = 1; i < 5; i++) begin
      frame(1'b1);
      expect_cmd($sformatf("t3_rr%0d", i), rr_code[i], rr_src[i]);
    end
    frame(1'b1);
    check("t3_drained", cmd_valid, 0);

    // Control priority and ESC flush
    do_reset();
    send_byte(8'h1C); send_byte(8'h3B); send_byte(8'h29);
    frame(1'b0);
    expect_cmd("t4_ctrl", 8'h29, 2'd0);
    send_byte(8'h76);
    frame(1'b1);
    expect_cmd("t4_esc", 8'h76, 2'd0);
    frame(1'b1);
    check("t4_flushed", cmd_valid, 0);
    check("t4_drop", drop_count, 0);

    // Overflow, write-with-pop on full, saturation
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'h4B);
    check("t5_drop2", drop_count, 2);
    tasta = 8'h4B; done = 1'b1; frame_tick = 1'b1;
    tick();
    done = 1'b0; frame_tick = 1'b0;
    tick();
    check("t5_popwrite_drop", drop_count, 2);
    expect_cmd("t5_g0", 8'h4B, 2'd2);
    for (int i = 1; i < 5; i++) begin
      frame(1'b1);
      expect_cmd($sformatf("t5_g%0d", i), 8'h4B, 2'd2);
    end
    frame(1'b1);
    check("t5_drained", cmd_valid, 0);
    for (int i = 0; i < 104; i++) send_byte(8'h4B);
    check("t5_drop102", drop_count, 8'h66);
    for (int i = 0; i < 200; i++) send_byte(8'h4B);
    check("t5_drop_sat", drop_count, 8'hFF);

    // Same-edge write and tick: not eligible until next tick
    do_reset();
    tasta = 8'h16; done = 1'b1; frame_tick = 1'b1;
    tick();
    done = 1'b0; frame_tick = 1'b0;
    check("t6_no_grant", cmd_valid, 0);
    tick();
    frame(1'b0);
    expect_cmd("t6_next", 8'h16, 2'd0);

    // Reset mid-sequence clears the break flag
    do_reset();
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h1C);
    frame(1'b0);
    expect_cmd("t7_fresh", 8'h1C, 2'd1);

    // Long done level yields a single byte event
    do_reset();
    tasta = 8'h3B; done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    done = 1'b0;
    tick();
    frame(1'b0);
    expect_cmd("t8_one", 8'h3B, 2'd2);
    frame(1'b1);
    check("t8_single", cmd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
